// File: rtl/pad_align_pkg.sv
// Shared types and defaults for the pad/align pipeline.
package pad_align_pkg;

  localparam int DEFAULT_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    MODE_MSB      = 2'd0,
    MODE_LSB_ZERO = 2'd1,
    MODE_LSB_SIGN = 2'd2
  } mode_e;

endpackage

// File: rtl/pad_align_comb.sv
// Per-mode width adaptation (pad, truncate or pass through); purely combinational.
// Inexact detection exists only when PAD_ALIGN_PIPE_STICKY_EN is defined.
module pad_align_comb
  import pad_align_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 8
) (
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [1:0]           in_mode,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_inexact
);

  // Mode 3 is undefined on the wire and falls back to MSB alignment.
  logic msb_align;
  assign msb_align = !((in_mode == MODE_LSB_ZERO) || (in_mode == MODE_LSB_SIGN));

  if (IN_WIDTH < OUT_WIDTH) begin : g_pad
    localparam int PAD = OUT_WIDTH - IN_WIDTH;
    logic ext_bit;
    assign ext_bit     = (in_mode == MODE_LSB_SIGN) & in_data[IN_WIDTH-1];
    assign out_data    = msb_align ? {in_data, {PAD{1'b0}}} : {{PAD{ext_bit}}, in_data};
    assign out_inexact = 1'b0;
  end else if (IN_WIDTH > OUT_WIDTH) begin : g_cut
    assign out_data = msb_align ? in_data[IN_WIDTH-1 -: OUT_WIDTH] : in_data[OUT_WIDTH-1:0];
`ifdef PAD_ALIGN_PIPE_STICKY_EN
    localparam int CUT = IN_WIDTH - OUT_WIDTH;
    assign out_inexact = msb_align ? |in_data[CUT-1:0] : |in_data[IN_WIDTH-1 -: CUT];
`else
    logic unused_dropped;
    assign unused_dropped = ^in_data;
    assign out_inexact    = 1'b0;
`endif
  end else begin : g_same
    logic unused_mode;
    assign unused_mode = msb_align;
    assign out_data    = in_data;
    assign out_inexact = 1'b0;
  end

endmodule

// File: rtl/pad_align_pipe.sv
// Width adapter behind a 2-entry output/skid pipeline; 1-cycle latency, in_ready is skid-empty only.
// Optional inexact flag and saturating drop counter enabled by PAD_ALIGN_PIPE_STICKY_EN.
module pad_align_pipe
  import pad_align_pkg::*;
#(
  parameter int IN_WIDTH    = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_inexact,
  output logic [COUNT_WIDTH-1:0] drop_count
);

  logic [OUT_WIDTH-1:0] adapt_data;
  logic                 adapt_inexact;
  logic [OUT_WIDTH-1:0] skid_data;
  logic                 skid_inexact;
  logic                 skid_valid;
  logic                 accept;
  logic                 out_load;

  pad_align_comb #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_comb (
    .in_data     (in_data),
    .in_mode     (in_mode),
    .out_data    (adapt_data),
    .out_inexact (adapt_inexact)
  );

  // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
  assign in_ready = resetn & ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign out_load = ~out_valid | out_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_inexact  <= 1'b0;
      skid_valid   <= 1'b0;
      skid_data    <= '0;
      skid_inexact <= 1'b0;
    end else if (out_load) begin
      out_valid <= skid_valid | accept;
      if (skid_valid) begin
        out_data     <= skid_data;
        out_inexact  <= skid_inexact;
        skid_valid   <= 1'b0;
      end else if (accept) begin
        out_data    <= adapt_data;
        out_inexact <= adapt_inexact;
      end
    end else if (accept) begin
      skid_valid   <= 1'b1;
      skid_data    <= adapt_data;
      skid_inexact <= adapt_inexact;
    end
  end

`ifdef PAD_ALIGN_PIPE_STICKY_EN
  logic [COUNT_WIDTH-1:0] drop_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      drop_q <= '0;
    end else if (out_valid && out_ready && out_inexact && !(&drop_q)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_pad_align_pipe.sv
// Directed bench: an 8->12 padding instance and a 12->8 truncating instance with a 4-bit counter.
module tb_pad_align_pipe;

  localparam bit STICKY =
`ifdef PAD_ALIGN_PIPE_STICKY_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn;

  logic        up_in_valid, up_in_ready, up_out_valid, up_out_ready, up_out_inexact;
  logic [7:0]  up_in_data;
  logic [1:0]  up_in_mode;
  logic [11:0] up_out_data;
  logic [15:0] up_drop_count;

  logic        dn_in_valid, dn_in_ready, dn_out_valid, dn_out_ready, dn_out_inexact;
  logic [11:0] dn_in_data;
  logic [1:0]  dn_in_mode;
  logic [7:0]  dn_out_data;
  logic [3:0]  dn_drop_count;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  pad_align_pipe #(.IN_WIDTH(8), .OUT_WIDTH(12), .COUNT_WIDTH(16)) dut_up (
    .clock(clock), .resetn(resetn),
    .in_valid(up_in_valid), .in_ready(up_in_ready), .in_data(up_in_data), .in_mode(up_in_mode),
    .out_valid(up_out_valid), .out_ready(up_out_ready), .out_data(up_out_data),
    .out_inexact(up_out_inexact), .drop_count(up_drop_count)
  );

  pad_align_pipe #(.IN_WIDTH(12), .OUT_WIDTH(8), .COUNT_WIDTH(4)) dut_dn (
    .clock(clock), .resetn(resetn),
    .in_valid(dn_in_valid), .in_ready(dn_in_ready), .in_data(dn_in_data), .in_mode(dn_in_mode),
    .out_valid(dn_out_valid), .out_ready(dn_out_ready), .out_data(dn_out_data),
    .out_inexact(dn_out_inexact), .drop_count(dn_drop_count)
  );

  task automatic test_reset();
    resetn = 1'b0;
    up_in_valid = 1'b0; up_in_data = '0; up_in_mode = '0; up_out_ready = 1'b0;
    dn_in_valid = 1'b0; dn_in_data = '0; dn_in_mode = '0; dn_out_ready = 1'b0;
    #2;
    checks++; if (up_out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", up_out_valid); else passed++;
    checks++; if (up_in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", up_in_ready); else passed++;
    checks++; if (up_out_data !== 12'h000) $display("FAIL rst_out_data got %h want 000", up_out_data); else passed++;
    checks++; if (up_out_inexact !== 1'b0) $display("FAIL rst_inexact got %b want 0", up_out_inexact); else passed++;
    checks++; if (up_drop_count !== 16'h0) $display("FAIL rst_drop_count got %h want 0", up_drop_count); else passed++;
    checks++; if (dn_in_ready !== 1'b0) $display("FAIL rst_dn_in_ready got %b want 0", dn_in_ready); else passed++;
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    #1;
    checks++; if (up_in_ready !== 1'b1) $display("FAIL rel_in_ready got %b want 1", up_in_ready); else passed++;
    checks++; if (up_out_valid !== 1'b0) $display("FAIL rel_out_valid got %b want 0", up_out_valid); else passed++;
  endtask

  task automatic test_pad();
    logic [7:0]  din [5] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h25};
    logic [1:0]  md  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    logic [11:0] exp [5] = '{12'hA50, 12'h0A5, 12'hFA5, 12'hA50, 12'h025};
    up_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      up_in_valid = 1'b1; up_in_data = din[i]; up_in_mode = md[i];
      @(posedge clock); #1;
      up_in_valid = 1'b0;
      @(negedge clock);
      checks++; if (up_out_valid !== 1'b1) $display("FAIL pad_valid[%0d] got %b want 1", i, up_out_valid); else passed++;
      checks++; if (up_out_data !== exp[i]) $display("FAIL pad_data[%0d] got %h want %h", i, up_out_data, exp[i]); else passed++;
      checks++; if (up_out_inexact !== 1'b0) $display("FAIL pad_inexact[%0d] got %b want 0", i, up_out_inexact); else passed++;
    end
    @(posedge clock);
    @(negedge clock);
    checks++; if (up_out_valid !== 1'b0) $display("FAIL pad_drain got %b want 0", up_out_valid); else passed++;
    checks++; if (up_drop_count !== 16'h0) $display("FAIL pad_drop_count got %h want 0", up_drop_count); else passed++;
  endtask

  task automatic test_trunc();
    logic [11:0] din [6] = '{12'hA51, 12'hA50, 12'hA51, 12'h3A0, 12'h0A0, 12'hA5F};
    logic [1:0]  md  [6] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3};
    logic [7:0]  exp [6] = '{8'hA5, 8'hA5, 8'h51, 8'hA0, 8'hA0, 8'hA5};
    logic        inx [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0]  exp_cnt = 4'd0;
    logic        exp_inx;
    dn_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_inx = STICKY & inx[i];
      @(posedge clock); #1;
      dn_in_valid = 1'b1; dn_in_data = din[i]; dn_in_mode = md[i];
      @(posedge clock); #1;
      dn_in_valid = 1'b0;
      @(negedge clock);
      checks++; if (dn_out_data !== exp[i]) $display("FAIL trunc_data[%0d] got %h want %h", i, dn_out_data, exp[i]); else passed++;
      checks++; if (dn_out_inexact !== exp_inx) $display("FAIL trunc_inexact[%0d] got %b want %b", i, dn_out_inexact, exp_inx); else passed++;
      if (exp_inx) exp_cnt = exp_cnt + 4'd1;
      @(posedge clock);
      @(negedge clock);
      checks++; if (dn_drop_count !== exp_cnt) $display("FAIL trunc_count[%0d] got %0d want %0d", i, dn_drop_count, exp_cnt); else passed++;
    end
  endtask

  task automatic test_backpressure();
    up_out_ready = 1'b0; up_in_mode = 2'd1;
    @(posedge clock); #1;
    up_in_valid = 1'b1; up_in_data = 8'd1;
    @(posedge clock); #1;
    up_in_data = 8'd2;
    @(posedge clock); #1;
    up_in_data = 8'd3;
    @(negedge clock);
    checks++; if (up_in_ready !== 1'b0) $display("FAIL bp_ready_low got %b want 0", up_in_ready); else passed++;
    checks++; if (up_out_data !== 12'h001) $display("FAIL bp_head got %h want 001", up_out_data); else passed++;
    @(posedge clock);
    @(negedge clock);
    checks++; if (up_out_valid !== 1'b1 || up_out_data !== 12'h001) $display("FAIL bp_stable got %b/%h want 1/001", up_out_valid, up_out_data); else passed++;
    checks++; if (up_in_ready !== 1'b0) $display("FAIL bp_ready_hold got %b want 0", up_in_ready); else passed++;
    up_out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++; if (up_out_data !== 12'h002) $display("FAIL bp_second got %h want 002", up_out_data); else passed++;
    checks++; if (up_in_ready !== 1'b1) $display("FAIL bp_ready_back got %b want 1", up_in_ready); else passed++;
    @(posedge clock); #1;
    up_in_valid = 1'b0;
    @(negedge clock);
    checks++; if (up_out_valid !== 1'b1 || up_out_data !== 12'h003) $display("FAIL bp_third got %b/%h want 1/003", up_out_valid, up_out_data); else passed++;
    @(posedge clock);
    @(negedge clock);
    checks++; if (up_out_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", up_out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, cycles = 0, drops = 0;
    dn_out_ready = 1'b1; dn_in_mode = 2'd1;
    @(posedge clock); #1;
    dn_in_valid = 1'b1; dn_in_data = 12'd0;
    while (got < 100 && cycles < 150) begin
      @(posedge clock);
      cycles++;
      if (dn_in_valid) sent++;
      #1;
      if (sent < 100) dn_in_data = 12'(sent);
      else dn_in_valid = 1'b0;
      @(negedge clock);
      if (dn_in_valid && !dn_in_ready) drops++;
      if (dn_out_valid) begin
        checks++; if (dn_out_data !== 8'(got)) $display("FAIL stream_data[%0d] got %h want %h", got, dn_out_data, 8'(got)); else passed++;
        got++;
      end
    end
    checks++; if (got != 100) $display("FAIL stream_count got %0d want 100", got); else passed++;
    checks++; if (cycles != 100) $display("FAIL stream_cycles got %0d want 100", cycles); else passed++;
    checks++; if (drops != 0) $display("FAIL stream_ready_drops got %0d want 0", drops); else passed++;
  endtask

  task automatic test_reset_mid();
    up_out_ready = 1'b0; up_in_mode = 2'd1;
    @(posedge clock); #1;
    up_in_valid = 1'b1; up_in_data = 8'd7;
    @(posedge clock); #1;
    up_in_data = 8'd8;
    @(posedge clock); #1;
    up_in_valid = 1'b0;
    @(negedge clock);
    checks++; if (up_out_valid !== 1'b1 || up_in_ready !== 1'b0) $display("FAIL mid_full got %b/%b want 1/0", up_out_valid, up_in_ready); else passed++;
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (up_out_valid !== 1'b0) $display("FAIL mid_out_valid got %b want 0", up_out_valid); else passed++;
    checks++; if (up_in_ready !== 1'b0) $display("FAIL mid_in_ready got %b want 0", up_in_ready); else passed++;
    checks++; if (dn_drop_count !== 4'd0) $display("FAIL mid_drop_count got %0d want 0", dn_drop_count); else passed++;
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    up_out_ready = 1'b1;
    #1;
    checks++; if (up_in_ready !== 1'b1 || up_out_valid !== 1'b0) $display("FAIL mid_release got %b/%b want 1/0", up_in_ready, up_out_valid); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (up_out_valid !== 1'b0) $display("FAIL mid_stale[%0d] got %b want 0", i, up_out_valid); else passed++;
    end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_cnt;
    dn_out_ready = 1'b1;
    @(posedge clock); #1;
    dn_in_valid = 1'b1; dn_in_data = 12'h001; dn_in_mode = 2'd0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (i == 19) dn_in_valid = 1'b0;
      @(negedge clock);
      exp_cnt = STICKY ? 4'((i > 15) ? 15 : i) : 4'd0;
      checks++; if (dn_out_inexact !== STICKY) $display("FAIL sat_inexact[%0d] got %b want %b", i, dn_out_inexact, STICKY); else passed++;
      checks++; if (dn_drop_count !== exp_cnt) $display("FAIL sat_count[%0d] got %0d want %0d", i, dn_drop_count, exp_cnt); else passed++;
    end
    @(posedge clock);
    @(negedge clock);
    exp_cnt = STICKY ? 4'hF : 4'h0;
    checks++; if (dn_drop_count !== exp_cnt) $display("FAIL sat_final got %h want %h", dn_drop_count, exp_cnt); else passed++;
    checks++; if (dn_out_valid !== 1'b0) $display("FAIL sat_drain got %b want 0", dn_out_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_pad();
    test_trunc();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
